// File: rtl/mac_array_pkg.sv
// Shared types and helpers for the output-stationary MAC array.
package mac_array_pkg;

  // Internal arithmetic width used by sat_add; operands are pre-extended to this width.
  localparam int unsigned MaxW = 64;

  typedef enum logic [0:0] {
    StAccum,
    StDrain
  } state_e;

  typedef struct packed {
    logic            sat;
    logic [MaxW-1:0] res;
  } sat_res_t;

  // Width of the row index: at least one bit even for a single-row array.
  function automatic int unsigned row_idx_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Adds a pre-extended accumulator and product, clamping to the acc_w-bit range.
  // Both inputs must already be sign- or zero-extended to MaxW bits.
  function automatic sat_res_t sat_add(input logic [MaxW-1:0] acc,
                                       input logic [MaxW-1:0] prod,
                                       input int unsigned     acc_w,
                                       input logic            is_signed);
    logic signed [MaxW:0] sum;
    logic signed [MaxW:0] hi;
    logic signed [MaxW:0] lo;
    sat_res_t             r;
    sum = $signed({acc[MaxW-1], acc}) + $signed({prod[MaxW-1], prod});
    if (is_signed) begin
      hi = (65'sd1 <<< (acc_w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (acc_w - 1));
    end else begin
      hi = (65'sd1 <<< acc_w) - 65'sd1;
      lo = '0;
    end
    if (sum > hi) begin
      r.sat = 1'b1;
      r.res = hi[MaxW-1:0];
    end else if (sum < lo) begin
      r.sat = 1'b1;
      r.res = lo[MaxW-1:0];
    end else begin
      r.sat = 1'b0;
      r.res = sum[MaxW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_cell.sv
// Single accumulating multiplier cell with a sticky saturation flag.
module mac_cell
  import mac_array_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  a,
  input  logic [IN_W-1:0]  b,
  input  logic             en,
  input  logic             first,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  localparam logic IsSigned = (SIGNED != 0);

  logic [ACC_W-1:0]          r_acc;
  logic                      r_sat;
  logic signed [IN_W:0]      w_a_ext;
  logic signed [IN_W:0]      w_b_ext;
  logic signed [2*IN_W+1:0]  w_prod;
  logic [MaxW-1:0]           w_prod64;
  logic [ACC_W-1:0]          w_base;
  logic [MaxW-1:0]           w_base64;
  sat_res_t                  w_res;
  logic                      w_unused_res;

  // One extra bit lets a single signed multiplier serve both operand modes.
  assign w_a_ext  = {IsSigned & a[IN_W-1], a};
  assign w_b_ext  = {IsSigned & b[IN_W-1], b};
  assign w_prod   = w_a_ext * w_b_ext;
  assign w_prod64 = {{(MaxW-2*IN_W-2){w_prod[2*IN_W+1]}}, w_prod};

  // The first beat of a tile starts from zero instead of the stale accumulator.
  assign w_base   = first ? '0 : r_acc;
  assign w_base64 = {{(MaxW-ACC_W){IsSigned & w_base[ACC_W-1]}}, w_base};

  assign w_res        = sat_add(w_base64, w_prod64, ACC_W, IsSigned);
  assign w_unused_res = ^w_res.res[MaxW-1:ACC_W];

  // Accumulate on each accepted beat; sat is sticky within a tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (en) begin
      r_acc <= w_res.res[ACC_W-1:0];
      r_sat <= (first ? 1'b0 : r_sat) | w_res.sat;
    end
  end

  assign acc = r_acc;
  assign sat = r_sat;

endmodule

// File: rtl/mac_array_acc.sv
// ROWS x COLS output-stationary MAC array: accumulates a tile, then drains row by row.
module mac_array_acc
  import mac_array_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned SIGNED    = 1,
  localparam int unsigned ROW_IDX_W = row_idx_w(ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [COLS*IN_W-1:0]  a_data,
  input  logic [ROWS*IN_W-1:0]  b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic [ROW_IDX_W-1:0]  out_row,
  output logic                  out_last,
  output logic                  out_sat
);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_first;
  logic [ROW_IDX_W-1:0]  r_row;
  logic                  w_accept;
  logic                  w_out_hs;
  logic                  w_row_last;
  logic [ACC_W-1:0]      w_acc [ROWS][COLS];
  logic                  w_sat [ROWS][COLS];

  assign w_accept   = in_valid & in_ready;
  assign w_out_hs   = out_valid & out_ready;
  assign w_row_last = (r_row == ROW_IDX_W'(ROWS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a tile ends on the in_last accept, drain ends on the last row handshake.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StAccum: if (w_accept && in_last) w_state_next = StDrain;
      StDrain: if (w_out_hs && w_row_last) w_state_next = StAccum;
      default: w_state_next = StAccum;
    endcase
  end

  // Stream handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StAccum: in_ready  = 1'b1;
      StDrain: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Track whether the next accepted beat starts a new tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_first <= in_last;
    end
  end

  // Drain row counter; wraps to zero after the final row so the next drain starts at row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (w_out_hs) begin
      r_row <= w_row_last ? '0 : r_row + 1'b1;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      mac_cell #(
        .IN_W   (IN_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_data[gj*IN_W +: IN_W]),
        .b     (b_data[gi*IN_W +: IN_W]),
        .en    (w_accept),
        .first (r_first),
        .acc   (w_acc[gi][gj]),
        .sat   (w_sat[gi][gj])
      );
    end
  end

  // Output row mux; data and sat read as zero outside DRAIN.
  always_comb begin
    out_data = '0;
    out_sat  = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (out_valid && (r_row == ROW_IDX_W'(r))) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          out_data[c*ACC_W +: ACC_W] = w_acc[r][c];
          out_sat                    = out_sat | w_sat[r][c];
        end
      end
    end
  end

  assign out_row  = r_row;
  assign out_last = out_valid & w_row_last;

endmodule
